// File: rtl/gpu_line_pkg.sv
// gpu_line_pkg: shared command type, FSM states and default coordinate width for the line scheduler
package gpu_line_pkg;
    localparam int COORD_W_DEF = 8;
    typedef struct packed {
        logic [COORD_W_DEF-1:0] x0, y0, x1, y1;
    } line_cmd_t;
    typedef enum logic [1:0] {IDLE, START, WAIT} sched_state_t;
endpackage

// File: rtl/line_cmd_scheduler_if.sv
// line_cmd_scheduler_if: requester command handshake plus rasterizer start/done and coordinates
interface line_cmd_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int COORD_W = 8
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0][4*COORD_W-1:0] req_cmd;
    logic                              eng_start;
    logic                              eng_done;
    logic [COORD_W-1:0]                eng_x0, eng_y0, eng_x1, eng_y1;
    modport master (
        output req_valid, req_cmd, eng_done,
        input  req_ready, eng_start, eng_x0, eng_y0, eng_x1, eng_y1
    );
    modport slave (
        input  req_valid, req_cmd, eng_done,
        output req_ready, eng_start, eng_x0, eng_y0, eng_x1, eng_y1
    );
endinterface

// File: rtl/line_cmd_fifo.sv
// line_cmd_fifo: circular command buffer; pointers carry an extra wrap bit to tell full from empty
module line_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [WIDTH-1:0]        data_i,
    output logic [WIDTH-1:0]        data_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_q + {{AW{1'b0}}, push_i};
            rd_q <= rd_q + {{AW{1'b0}}, pop_i};
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end
    assign data_o  = mem_q[rd_q[AW-1:0]];
    assign count_o = wr_q - rd_q;
    assign full_o  = count_o == (AW+1)'(DEPTH);
    assign empty_o = wr_q == rd_q;
endmodule

// File: rtl/line_cmd_scheduler.sv
// line_cmd_scheduler: round-robin intake of line commands, FIFO buffering, and one-at-a-time
// issue to the shared rasterizer over its start/done handshake.
module line_cmd_scheduler
    import gpu_line_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int COORD_W    = COORD_W_DEF
) (
    input  logic                         clk,
    input  logic                         n_rst,
    line_cmd_scheduler_if.slave          bus,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [15:0]                  lines_drawn
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = 4 * COORD_W;
    logic [IW-1:0]      last_q, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               push, pop, full, empty;
    logic [CW-1:0]      head, eng_q;
    logic [15:0]        lines_q, lines_d;
    sched_state_t       state_q, state_d;
    // Scan downward so the requester nearest after last_q is the one left in gnt_idx.
    always_comb begin
        gnt     = '0;
        gnt_idx = last_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req_valid[(int'(last_q) + k) % NUM_REQ]) gnt_idx = IW'((int'(last_q) + k) % NUM_REQ);
        end
        gnt[gnt_idx] = !full && bus.req_valid[gnt_idx];
    end
    assign push          = |gnt;
    assign bus.req_ready = gnt;
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        lines_d = lines_q;
        case (state_q)
            IDLE: begin
                pop     = !empty;
                state_d = empty ? IDLE : START;
            end
            START: state_d = WAIT;
            WAIT: begin
                state_d = bus.eng_done ? IDLE : WAIT;
                lines_d = lines_q + {15'd0, bus.eng_done};
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            lines_q <= '0;
            eng_q   <= '0;
        end else begin
            state_q <= state_d;
            lines_q <= lines_d;
            if (push) last_q <= gnt_idx;
            if (pop) eng_q <= head;
        end
    end
    line_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CW)) u_fifo (
        .clk    (clk),
        .n_rst  (n_rst),
        .push_i (push),
        .pop_i  (pop),
        .data_i (bus.req_cmd[gnt_idx]),
        .data_o (head),
        .count_o(fifo_count),
        .full_o (full),
        .empty_o(empty)
    );
    assign bus.eng_start = state_q == START;
    assign {bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1} = eng_q;
    assign busy        = state_q != IDLE || !empty;
    assign lines_drawn = lines_q;
endmodule

// File: tb/tb_line_cmd_scheduler.sv
// tb_line_cmd_scheduler: directed scenarios plus randomized traffic against a queue-based model
module tb_line_cmd_scheduler;
    import gpu_line_pkg::*;
    localparam int N = 2;
    localparam int DEPTH = 4;
    localparam int W = COORD_W_DEF;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [15:0] lines_drawn;
    int total, bad;
    line_cmd_scheduler_if #(.NUM_REQ(N), .COORD_W(W)) bus ();
    line_cmd_scheduler #(.NUM_REQ(N), .FIFO_DEPTH(DEPTH), .COORD_W(W)) dut (
        .clk(clk), .n_rst(n_rst), .bus(bus), .busy(busy), .fifo_count(fifo_count), .lines_drawn(lines_drawn)
    );
    always #5 clk = ~clk;

    // Reference model: a queue of pending commands, the line being drawn, and a done counter.
    int          m_last;
    line_cmd_t   m_q[$];
    line_cmd_t   m_eng;
    bit          m_issued, m_start;
    logic [15:0] m_lines;
    line_cmd_t   sent[$];

    function automatic logic [N-1:0] exp_ready();
        if (m_q.size() >= DEPTH) return '0;
        for (int k = 1; k <= N; k++)
            if (bus.req_valid[(m_last + k) % N]) return N'(1) << ((m_last + k) % N);
        return '0;
    endfunction

    function automatic line_cmd_t rnd_cmd();
        line_cmd_t c = line_cmd_t'($urandom);
        if ($urandom_range(3) == 0) begin
            c.x1 = c.x0;
            c.y1 = c.y0;
        end
        return c;
    endfunction

    task automatic model_reset();
        m_last = N - 1;
        m_q.delete();
        m_eng = '0;
        m_issued = 0;
        m_start = 0;
        m_lines = '0;
    endtask

    task automatic tick();
        logic [N-1:0] g = exp_ready();
        if (m_start) m_start = 0;
        else if (m_issued && bus.eng_done) begin
            m_issued = 0;
            m_lines++;
        end else if (!m_issued && m_q.size() > 0) begin
            m_eng = m_q.pop_front();
            m_issued = 1;
            m_start = 1;
        end
        for (int i = 0; i < N; i++)
            if (g[i]) begin
                m_q.push_back(bus.req_cmd[i]);
                m_last = i;
            end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        bus.req_valid = '0;
        bus.eng_done = 1'b0;
        n_rst = 1'b0;
        #1;
        n_rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({bus.eng_start, bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1, fifo_count, busy, lines_drawn} !== 53'd0 || bus.req_ready !== 2'b00) begin
            bad++;
            $display("FAIL reset_values got ready=%b start=%b cnt=%0d busy=%b lines=%0d exp all zero", bus.req_ready, bus.eng_start, fifo_count, busy, lines_drawn);
        end
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        bus.req_cmd[0] = {8'd3, 8'd5, 8'd10, 8'd7};
        bus.req_valid = 2'b01;
        #1;
        total++;
        if (bus.req_ready !== 2'b01) begin
            bad++;
            $display("FAIL single_ready got=%b exp=01", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        total++;
        if (fifo_count !== 3'd1 || bus.eng_start !== 1'b0) begin
            bad++;
            $display("FAIL single_queued got cnt=%0d start=%b exp cnt=1 start=0", fifo_count, bus.eng_start);
        end
        tick();
        total++;
        if (bus.eng_start !== 1'b1 || {bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1} !== {8'd3, 8'd5, 8'd10, 8'd7}) begin
            bad++;
            $display("FAIL single_start got start=%b xy=%h exp start=1 xy=03050a07", bus.eng_start, {bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1});
        end
        tick();
        total++;
        if (bus.eng_start !== 1'b0 || busy !== 1'b1 || bus.eng_x1 !== 8'd10) begin
            bad++;
            $display("FAIL single_wait got start=%b busy=%b x1=%0d exp start=0 busy=1 x1=10", bus.eng_start, busy, bus.eng_x1);
        end
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        total++;
        if (lines_drawn !== 16'd1 || busy !== 1'b0 || bus.eng_y1 !== 8'd7) begin
            bad++;
            $display("FAIL single_done got lines=%0d busy=%b y1=%0d exp lines=1 busy=0 y1=7", lines_drawn, busy, bus.eng_y1);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_g;
        pulse_reset();
        sent.delete();
        bus.req_cmd[0] = rnd_cmd();
        bus.req_cmd[1] = rnd_cmd();
        bus.req_valid = 2'b11;
        for (int c = 0; c < 7; c++) begin
            exp_g = (c >= 5) ? 2'b00 : ((c % 2) != 0) ? 2'b10 : 2'b01;
            #1;
            total++;
            if (bus.req_ready !== exp_g) begin
                bad++;
                $display("FAIL fair_grant cyc=%0d got=%b exp=%b", c, bus.req_ready, exp_g);
            end
            for (int i = 0; i < N; i++) if (exp_g[i]) sent.push_back(bus.req_cmd[i]);
            tick();
            for (int i = 0; i < N; i++) if (exp_g[i]) bus.req_cmd[i] = rnd_cmd();
        end
        total++;
        if (fifo_count !== 3'd4) begin
            bad++;
            $display("FAIL fair_full got cnt=%0d exp=4", fifo_count);
        end
    endtask

    task automatic test_full_pop();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        #1;
        total++;
        if (bus.req_ready !== 2'b00 || fifo_count !== 3'd4) begin
            bad++;
            $display("FAIL full_pop_ready got ready=%b cnt=%0d exp ready=00 cnt=4", bus.req_ready, fifo_count);
        end
        tick();
        bus.req_valid = '0;
        total++;
        if (fifo_count !== 3'd3 || bus.eng_start !== 1'b1) begin
            bad++;
            $display("FAIL full_pop_count got cnt=%0d start=%b exp cnt=3 start=1", fifo_count, bus.eng_start);
        end
    endtask

    task automatic test_order();
        line_cmd_t exp_c;
        int w;
        void'(sent.pop_front());
        while (sent.size() > 0) begin
            w = 0;
            while (!bus.eng_start && w < 8) begin
                tick();
                w++;
            end
            exp_c = sent.pop_front();
            total++;
            if (bus.eng_start !== 1'b1 || {bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1} !== exp_c) begin
                bad++;
                $display("FAIL order got start=%b xy=%h exp start=1 xy=%h", bus.eng_start, {bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1}, exp_c);
            end
            tick();
            bus.eng_done = 1'b1;
            tick();
            bus.eng_done = 1'b0;
        end
    endtask

    task automatic test_spurious();
        logic [15:0] l0 = m_lines;
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        total++;
        if (lines_drawn !== l0 || busy !== 1'b0 || bus.eng_start !== 1'b0) begin
            bad++;
            $display("FAIL spurious_idle got lines=%0d busy=%b start=%b exp lines=%0d busy=0 start=0", lines_drawn, busy, bus.eng_start, l0);
        end
        bus.req_cmd[1] = rnd_cmd();
        bus.req_valid = 2'b10;
        tick();
        bus.req_valid = '0;
        tick();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        total++;
        if (lines_drawn !== l0 || busy !== 1'b1 || bus.eng_start !== 1'b0) begin
            bad++;
            $display("FAIL spurious_start got lines=%0d busy=%b start=%b exp lines=%0d busy=1 start=0", lines_drawn, busy, bus.eng_start, l0);
        end
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        total++;
        if (lines_drawn !== l0 + 16'd1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL spurious_real got lines=%0d busy=%b exp lines=%0d busy=0", lines_drawn, busy, l0 + 16'd1);
        end
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.req_cmd[c % 2] = rnd_cmd();
        end
        bus.req_valid = '0;
        total++;
        if (fifo_count !== 3'd3 || busy !== 1'b1 || bus.eng_start !== 1'b0) begin
            bad++;
            $display("FAIL rmid_setup got cnt=%0d busy=%b start=%b exp cnt=3 busy=1 start=0", fifo_count, busy, bus.eng_start);
        end
        #2;
        n_rst = 1'b0;
        #1;
        total++;
        if ({bus.eng_start, bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1, fifo_count, busy, lines_drawn} !== 53'd0 || bus.req_ready !== 2'b00) begin
            bad++;
            $display("FAIL rmid_clear got start=%b cnt=%0d busy=%b lines=%0d exp all zero", bus.eng_start, fifo_count, busy, lines_drawn);
        end
        model_reset();
        #1;
        n_rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (bus.eng_start !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rmid_quiet cyc=%0d got start=%b busy=%b exp 0 0", c, bus.eng_start, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] rdy;
        logic [52:0]  got, exp_v;
        for (int c = 0; c < 400; c++) begin
            #1;
            total++;
            if (bus.req_ready !== exp_ready()) begin
                bad++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, bus.req_ready, exp_ready());
            end
            rdy = bus.req_ready;
            tick();
            got = {bus.eng_start, bus.eng_x0, bus.eng_y0, bus.eng_x1, bus.eng_y1, fifo_count, busy, lines_drawn};
            exp_v = {m_start, m_eng, 3'(m_q.size()), m_issued || m_q.size() != 0, m_lines};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL rand_out cyc=%0d got=%h exp=%h", c, got, exp_v);
            end
            for (int i = 0; i < N; i++)
                if (!bus.req_valid[i] || rdy[i]) begin
                    bus.req_valid[i] = $urandom_range(2) != 0;
                    bus.req_cmd[i] = rnd_cmd();
                end
            bus.eng_done = $urandom_range(3) == 0;
        end
        bus.req_valid = '0;
        bus.eng_done = 1'b0;
    endtask

    task automatic test_wrap();
        pulse_reset();
        force dut.lines_q = 16'hFFFF;
        #1;
        release dut.lines_q;
        m_lines = 16'hFFFF;
        total++;
        if (lines_drawn !== 16'hFFFF) begin
            bad++;
            $display("FAIL wrap_preload got=%h exp=ffff", lines_drawn);
        end
        bus.req_cmd[0] = rnd_cmd();
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
        total++;
        if (lines_drawn !== 16'h0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL wrap got lines=%h busy=%b exp lines=0000 busy=0", lines_drawn, busy);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        bus.req_valid = '0;
        bus.req_cmd = '0;
        bus.eng_done = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_full_pop();
        test_order();
        test_spurious();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/line_cmd_scheduler.md
# line_cmd_scheduler

Front-end controller for the Bresenham line rasterizer. Collects line-draw commands from several requesters through a round-robin arbiter and buffers them in a small FIFO. It then issues them one at a time to the rasterizer using its `start`/`done` handshake, and holds the coordinates stable for the whole draw. It sits between the command decoders (CPU/command interface) and the single rasterizer instance, which makes that instance a shared resource.

## Interface
Parameters:
- `NUM_REQ`, 2 — number of requesters (2..4).
- `FIFO_DEPTH`, 4 — command FIFO entries; power of 2, ≥2.
- `COORD_W`, 8 — coordinate width.

Ports:
- `clk` in 1 — single clock; all logic on the rising edge.
- `n_rst` in 1 — asynchronous, active-low reset.
- `req_valid` in `NUM_REQ` — requester i has a command.
- `req_cmd` in `NUM_REQ` × `line_cmd_t` — packed `{x0,y0,x1,y1}`, `4*COORD_W` bits each.
- `req_ready` out `NUM_REQ` — one-hot or zero; grant to requester i.
- `eng_start` out 1 — one-cycle start pulse to the rasterizer.
- `eng_x0`, `eng_y0`, `eng_x1`, `eng_y1` out `COORD_W` — registered coordinates to the rasterizer.
- `eng_done` in 1 — rasterizer completion pulse.
- `busy` out 1 — FSM not IDLE or FIFO non-empty.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1` — occupied FIFO entries.
- `lines_drawn` out 16 — completed-line counter.

## Operation
**Accept path**
- When `fifo_count < FIFO_DEPTH` (registered value), the arbiter grants the first valid requester, searching from `last_grant+1` modulo `NUM_REQ`.
- `req_ready` is combinational from `req_valid` and the registered pointer.
- Transfer happens on `req_valid[i] && req_ready[i]`. `last_grant` updates to i on a transfer only.
- When the FIFO is full, all `req_ready` bits are 0, even if a pop occurs in the same cycle.
- A requester holds `req_cmd` stable while valid and not granted.

**Issue FSM** (states IDLE, START, WAIT)
- IDLE: if the FIFO is non-empty, pop the head into the `eng_*` registers and go to START. Otherwise stay.
- START: `eng_start`=1 for exactly this cycle, then go to WAIT.
- WAIT: on `eng_done`, increment `lines_drawn` and go to IDLE. Otherwise stay.
- `eng_done` in IDLE or START is ignored and does not count.
- `eng_*` coordinates change only on a pop. They stay stable from START through the `eng_done` cycle and after.
- Push and pop in the same cycle leave `fifo_count` unchanged. Data is ordered first-in first-out.
- Degenerate lines (start point equals end point) are issued normally.
- `lines_drawn` wraps from 16'hFFFF to 0.

## Timing
- Reset values: `req_ready` 0 (FIFO empty, so it follows `req_valid` combinationally once reset is released); `eng_start` 0; `eng_*` 0; `busy` 0; `fifo_count` 0; `lines_drawn` 0; FSM IDLE; `last_grant` = `NUM_REQ-1`, so requester 0 has first priority.
- Latency, empty and idle: accept on edge T → pop on edge T+1 → `eng_start` high for the cycle between edges T+1 and T+2.
- Back-to-back throughput: `eng_done` seen on edge D → IDLE. The next pop is on edge D+1 and `eng_start` is high in cycle D+1..D+2. Minimum gap is 2 cycles between a done and the next start.
- `busy` is registered-state derived, with no combinational path from inputs.
- Reset mid-operation (`n_rst` low at any time): all state clears asynchronously. Queued and in-flight commands are discarded. `eng_start` drops immediately.

## Structure
- Package `gpu_line_pkg`:
  - `line_cmd_t` packed struct `{x0,y0,x1,y1}` of `COORD_W` each.
  - FSM enum `sched_state_t` {IDLE, START, WAIT}.
  - Default `COORD_W` constant.
- Sub-module `line_cmd_fifo`:
  - Parameterised by depth and width.
  - Ports: push/pop/data in and out, count, full, empty.
  - Pointers one bit wider than the index, for full/empty detection.
- Arbiter and FSM stay inline in `line_cmd_scheduler`.

## Test plan
- Single command: requester 0 sends (3,5)→(10,7). Expect `req_ready[0]` in the same cycle, `eng_start` 2 cycles later with `eng_x0`=3, `eng_y0`=5, `eng_x1`=10, `eng_y1`=7. After `eng_done`, `lines_drawn`=1 and `busy`=0.
- Fairness: both requesters valid continuously with the rasterizer stalled. Grants alternate 0,1,0,1 until `fifo_count`=4, then `req_ready`=0. Pops are issued in that same order.
- Full with simultaneous pop: FIFO full and IDLE popping. `req_ready` stays 0 that cycle and `fifo_count` goes 4→3.
- Spurious done: `eng_done` pulsed in IDLE and in START. FSM unchanged and `lines_drawn` unchanged.
- Reset mid-draw: 3 queued, FSM in WAIT, assert `n_rst`. All outputs return to reset values at once. After release, no `eng_start` until a new command arrives.
- Counter wrap: preload by issuing 65536 lines (or force). `lines_drawn` goes FFFF→0000.
